// File: rtl/abcd_scheduler_pkg.sv
// Shared types and constants for the ABCD scheduler: FSM encoding, phase lengths
// and the operand byte lanes of the packed {A,B,C,D} request word.
package abcd_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int LOAD_CNT    = 4;
    localparam int TIMEOUT_CYC = 4;

    localparam logic [1:0] LOAD_LAST = 2'(LOAD_CNT - 1);
    localparam logic [1:0] WAIT_LAST = 2'(TIMEOUT_CYC - 1);

    localparam int LANE_A = 3;
    localparam int LANE_B = 2;
    localparam int LANE_C = 1;
    localparam int LANE_D = 0;

    // Operand index k walks A, B, C, D, i.e. from the most significant byte down.
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        b = '0;
        case (k)
            2'd0: b = word[8*LANE_A +: 8];
            2'd1: b = word[8*LANE_B +: 8];
            2'd2: b = word[8*LANE_C +: 8];
            2'd3: b = word[8*LANE_D +: 8];
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/abcd_scheduler_arb.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is taken.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] winner
);

    logic favour1;

    always_comb begin
        winner = req;
        if (req == 2'b11)
            winner = favour1 ? 2'b10 : 2'b01;
    end

    // After serving requester 0 favour requester 1, and vice versa.
    always_ff @(posedge clock) begin
        if (!reset)
            favour1 <= 1'b0;
        else if (update && winner != 2'b00)
            favour1 <= winner[0];
    end

endmodule

// File: rtl/abcd_scheduler.sv
// Arbitrates two requesters onto one (A+B)-(C+D) datapath: clears it, streams the
// four operand bytes in, then waits for valid or a timeout and reports the result.
module abcd_scheduler
    import abcd_scheduler_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] req_data0,
    input  logic [31:0] req_data1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [8:0]  result,
    output logic        err,
    output logic        busy,
    output logic        dp_reset,
    output logic        capture,
    output logic [1:0]  op,
    output logic [7:0]  d_in,
    input  logic        dp_valid,
    input  logic [8:0]  dp_result
);

    state_t      state, next_state;
    logic [1:0]  winner;
    logic [1:0]  k;
    logic [1:0]  wcnt;
    logic [31:0] hold;

    rr_arbiter2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .update (state == IDLE),
        .winner (winner)
    );

    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req != 2'b00) next_state = CLEAR;
            CLEAR:   next_state = LOAD;
            LOAD:    if (k == LOAD_LAST) next_state = WAIT;
            WAIT:    if (dp_valid || wcnt == WAIT_LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        capture = (state == LOAD);
        op      = capture ? k : 2'd0;
        d_in    = capture ? lane_byte(hold, k) : 8'd0;
    end

    // Operands are latched at grant so later req/req_data changes cannot leak in.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hold     <= '0;
            grant    <= '0;
            done     <= '0;
            result   <= '0;
            err      <= 1'b0;
            k        <= '0;
            wcnt     <= '0;
            dp_reset <= 1'b0;
        end else begin
            dp_reset <= (next_state != CLEAR);
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        hold  <= winner[1] ? req_data1 : req_data0;
                        grant <= winner;
                        k     <= '0;
                        wcnt  <= '0;
                    end
                end
                LOAD: k <= k + 2'd1;
                WAIT: begin
                    wcnt <= wcnt + 2'd1;
                    if (dp_valid) begin
                        result <= dp_result;
                        err    <= 1'b0;
                        done   <= grant;
                    end else if (wcnt == WAIT_LAST) begin
                        result <= '0;
                        err    <= 1'b1;
                        done   <= grant;
                    end
                end
                DONE: begin
                    done  <= '0;
                    grant <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_abcd_scheduler.sv
// Directed bench for abcd_scheduler with a behavioural datapath and a scoreboard
// of expected {done, result, err} per transaction.
module tb_abcd_scheduler;

    logic        clock;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] req_data0, req_data1;
    logic [1:0]  grant, done;
    logic [8:0]  result;
    logic        err, busy, dp_reset, capture;
    logic [1:0]  op;
    logic [7:0]  d_in;
    logic        dp_valid;
    logic [8:0]  dp_result;

    typedef struct packed {
        logic [1:0] done;
        logic [8:0] res;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic dp_kill;

    abcd_scheduler dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .grant     (grant),
        .done      (done),
        .result    (result),
        .err       (err),
        .busy      (busy),
        .dp_reset  (dp_reset),
        .capture   (capture),
        .op        (op),
        .d_in      (d_in),
        .dp_valid  (dp_valid),
        .dp_result (dp_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Datapath stand-in: captures operands, answers valid two cycles after D.
    logic [7:0] ra, rb, rc, rd;
    logic       stage;
    always @(posedge clock) begin
        if (!dp_reset) begin
            ra <= '0; rb <= '0; rc <= '0; rd <= '0;
            stage <= 1'b0; dp_valid <= 1'b0; dp_result <= '0;
        end else begin
            if (capture) begin
                case (op)
                    2'd0: ra <= d_in;
                    2'd1: rb <= d_in;
                    2'd2: rc <= d_in;
                    default: rd <= d_in;
                endcase
            end
            stage <= capture && op == 2'd3;
            if (stage && !dp_kill) begin
                dp_valid  <= 1'b1;
                dp_result <= ({1'b0, ra} + {1'b0, rb}) - ({1'b0, rc} + {1'b0, rd});
            end
        end
    end

    function automatic logic [8:0] ref_res(input logic [31:0] d);
        logic [8:0] ab, cd;
        ab = {1'b0, d[31:24]} + {1'b0, d[23:16]};
        cd = {1'b0, d[15:8]} + {1'b0, d[7:0]};
        return ab - cd;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_grant"},    32'(grant),    32'd0);
        chk({t, "_done"},     32'(done),     32'd0);
        chk({t, "_result"},   32'(result),   32'd0);
        chk({t, "_err"},      32'(err),      32'd0);
        chk({t, "_busy"},     32'(busy),     32'd0);
        chk({t, "_capture"},  32'(capture),  32'd0);
        chk({t, "_op"},       32'(op),       32'd0);
        chk({t, "_d_in"},     32'(d_in),     32'd0);
        chk({t, "_dp_reset"}, 32'(dp_reset), 32'd0);
    endtask

    // Called on a negedge; follows one transaction from grant to done.
    task automatic txn(input logic [1:0] r, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] win, input logic kill, input logic mutate,
                       input logic [1:0] nreq);
        logic [31:0] wd;
        exp_t        e;
        int          n, lat;
        logic        saw_idle;
        wd = win[1] ? d1 : d0;
        req = r; req_data0 = d0; req_data1 = d1; dp_kill = kill;
        e.done = win; e.res = kill ? 9'd0 : ref_res(wd); e.err = kill;
        sb.push_back(e);
        saw_idle = !busy;
        n = 0;
        do begin
            @(negedge clock);
            if (!busy && grant == 2'b00) saw_idle = 1'b1;
            n++;
        end while (grant == 2'b00 && n < 20);
        chk("grant", 32'(grant), 32'(win));
        chk("idle_gap", 32'(saw_idle), 32'd1);
        chk("clear_phase", 32'({dp_reset, capture, busy}), 32'b001);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("capture", 32'(capture), 32'd1);
            chk("op", 32'(op), 32'(k));
            chk("d_in", 32'(d_in), 32'(wd[8*(3-k) +: 8]));
            if (mutate && k == 1) begin
                req_data0 = ~req_data0;
                req_data1 = ~req_data1;
                req = 2'b00;
            end
        end
        lat = 5;
        do begin
            @(negedge clock);
            lat++;
        end while (done == 2'b00 && lat < 30);
        chk("latency", 32'(lat), kill ? 32'd10 : 32'd8);
        req = nreq;
    endtask

    always @(negedge clock) begin
        if (done !== 2'b00) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done observed %0b expected none", done);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("done", 32'(done), 32'(mon_e.done));
                chk("result", 32'(result), 32'(mon_e.res));
                chk("err", 32'(err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        int n;
        reset = 1'b0; req = 2'b00; req_data0 = '0; req_data1 = '0; dp_kill = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset("por");
        reset = 1'b1;

        txn(2'b01, {8'd10, 8'd20, 8'd5, 8'd7}, 32'h0, 2'b01, 1'b0, 1'b0, 2'b00);
        txn(2'b01, {8'd1, 8'd2, 8'd100, 8'd50}, 32'h0, 2'b01, 1'b0, 1'b0, 2'b00);
        txn(2'b01, {8'd255, 8'd255, 8'd0, 8'd0}, 32'h0, 2'b01, 1'b0, 1'b0, 2'b00);
        txn(2'b01, 32'h11223344, 32'h0, 2'b01, 1'b0, 1'b1, 2'b00);
        txn(2'b10, 32'h0, 32'h0A0B0C0D, 2'b10, 1'b1, 1'b0, 2'b00);
        txn(2'b10, 32'h0, 32'h40302010, 2'b10, 1'b0, 1'b0, 2'b00);

        // Abort in LOAD k=2, then the held request runs again from scratch.
        req = 2'b01; req_data0 = 32'h08070605; dp_kill = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(capture && op == 2'd2) && n < 20);
        chk("reach_load2", 32'(n < 20), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        chk_reset("mid");
        reset = 1'b1;
        txn(2'b01, 32'h08070605, 32'h0, 2'b01, 1'b0, 1'b0, 2'b00);

        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        txn(2'b11, 32'h05050101, 32'h09080706, 2'b01, 1'b0, 1'b0, 2'b11);
        txn(2'b11, 32'h05050101, 32'h09080706, 2'b10, 1'b0, 1'b0, 2'b11);
        txn(2'b11, 32'h05050101, 32'h09080706, 2'b01, 1'b0, 1'b0, 2'b00);

        repeat (4) @(negedge clock);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/abcd_scheduler.md
ABCD_SCHEDULER -- requirements
Module: abcd_scheduler

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-low; reset==0 at a rising edge clears all state.
REQ-003 req  in  2  per-requester request, bit i = requester i; level, held until done[i].
REQ-004 req_data0  in  32  requester 0 operands {A[31:24],B[23:16],C[15:8],D[7:0]}, unsigned.
REQ-005 req_data1  in  32  requester 1 operands, same packing.
REQ-006 grant  out  2  one-hot, or 0 when idle; marks the requester owning the datapath.
REQ-007 done  out  2  one-cycle pulse to the owning requester; result/err are valid in that cycle.
REQ-008 result  out  9  registered datapath result, (A+B)-(C+D) mod 2^9, two's complement.
REQ-009 err  out  1  valid with done; 1 = datapath timeout.
REQ-010 busy  out  1  1 in every state except IDLE.
REQ-011 dp_reset  out  1  active-low synchronous clear to the datapath's flag, valid and operand registers.
REQ-012 capture  out  1  datapath operand-capture strobe.
REQ-013 op  out  2  datapath operand select: 00=A, 01=B, 10=C, 11=D.
REQ-014 d_in  out  8  datapath operand byte.
REQ-015 dp_valid  in  1  datapath valid.
REQ-016 dp_result  in  9  datapath result.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, LOAD, WAIT, DONE.
REQ-018 IDLE: if req!=0, the arbiter picks a winner, operands are latched into a 32-bit hold register, grant is set, and the next state is CLEAR; otherwise the FSM stays in IDLE.
REQ-019 CLEAR: exactly 1 cycle; dp_reset=0, capture=0.
REQ-020 LOAD: exactly 4 cycles, 2-bit index k=0..3; capture=1, op=k, d_in=hold byte k (A first); next state after k=3 is WAIT.
REQ-021 WAIT: capture=0; wait counter increments each cycle.
REQ-022 WAIT exit on valid: dp_valid=1 latches dp_result into result, sets err=0, and moves to DONE.
REQ-023 WAIT exit on timeout: 4 cycles without dp_valid sets result=0, err=1, and moves to DONE.
REQ-024 DONE: exactly 1 cycle; done[winner]=1; then grant is cleared and the FSM returns to IDLE.
REQ-025 Arbitration SHALL be round-robin, 2-way, with the priority pointer favouring the requester not last served; the pointer updates only at grant.
REQ-026 Both req bits set in IDLE: the pointer decides; the loser is granted in the next IDLE, so there is no starvation.
REQ-027 Changes to req or req_data after grant SHALL NOT affect the transaction in progress.
REQ-028 A requester that drops req mid-transaction still completes; its done is delivered regardless.
REQ-029 Nominal latency: done is asserted 8 cycles after the IDLE grant cycle (CLEAR 1, LOAD 4, WAIT 2).
REQ-030 dp_reset SHALL be 1 in every state except CLEAR; during the scheduler's own reset it SHALL be 0.
REQ-031 Back-to-back requests: IDLE is occupied for at least 1 cycle between transactions.

Reset
REQ-032 On reset==0: state=IDLE, grant=0, done=0, result=0, err=0, busy=0, capture=0, op=0, d_in=0, dp_reset=0, pointer favours requester 0, all counters and the hold register = 0.
REQ-033 Reset mid-transaction aborts the transaction without asserting done; the requester re-arbitrates after reset.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE..DONE), LOAD_CNT=4, TIMEOUT_CYC=4, and the operand byte-lane constants.
REQ-035 Arbitration SHALL live in one sub-module, rr_arbiter2 (inputs: req, update, clock, reset; output: one-hot winner).
REQ-036 All outputs SHALL be registered or decoded directly from state only; there is no combinational path from req to capture.

Verification
REQ-037 req=01, data0 A=10,B=20,C=5,D=7 -> ops 00,01,10,11 with d_in 10,20,5,7; done=01 8 cycles later; result=9'h012, err=0.
REQ-038 data0 A=1,B=2,C=100,D=50 -> result=9'h16D (-147); A=B=255,C=D=0 -> result=9'h1FE.
REQ-039 req=11 from reset -> grant 01 first, then 10; then req=11 again -> 01 (alternation); no back-to-back same winner.
REQ-040 dp_valid forced 0 -> after 4 WAIT cycles done pulses with err=1, result=0; next transaction succeeds normally.
REQ-041 reset=0 during LOAD k=2 -> next cycle all REQ-032 values, no done; release reset with req held -> full transaction completes correctly.
REQ-042 req_data0 changed during LOAD -> d_in still shows the bytes latched at grant.
